// File: rtl/vga_pkg.sv
// vga_pkg: constants and helpers shared by the VGA display path.
//   - Screen geometry (640x480 visible, 10-bit coordinates).
//   - Default pixel colour width.
//   - color_bar(): expands a 3-bit bar selector into R/G/B fields of a
//     given width. Each field is all-ones if its selector bit is set.
package vga_pkg;

    localparam int unsigned H_DISPLAY     = 32'd640;
    localparam int unsigned V_DISPLAY     = 32'd480;
    localparam int unsigned COORD_W       = 32'd10;
    localparam int unsigned RGB_W_DEFAULT = 32'd3;

    // Widest colour the helper can build; callers keep the low RGB_W bits.
    localparam int unsigned RGB_MAX_W     = 32'd30;

    // bar_sel[2] drives R (MSBs), bar_sel[1] drives G, bar_sel[0] drives B (LSBs).
    function automatic logic [RGB_MAX_W-1:0] color_bar(
        input logic [2:0]  bar_sel,
        input int unsigned field_w
    );
        logic [RGB_MAX_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < RGB_MAX_W; i++) begin
            if (i < field_w) begin
                res[i] = bar_sel[0];
            end else if (i < 32'd2 * field_w) begin
                res[i] = bar_sel[1];
            end else if (i < 32'd3 * field_w) begin
                res[i] = bar_sel[2];
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register that advances only on en_i.
// Ports:
//   clk_i   system clock
//   srst_i  synchronous active-high clear of every stage
//   en_i    shift enable (pixel tick)
//   din_i   value captured into stage 1
//   dout_o  last stage (registered)
//   pre_o   value the last stage will load on the next enabled edge;
//           lets the owner detect edges of the output one cycle early
module vga_delay_line #(
    parameter int unsigned WIDTH = 32'd1,
    parameter int unsigned DEPTH = 32'd1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [WIDTH-1:0] pre_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    generate
        if (DEPTH == 32'd1) begin : g_single
            assign stage_d = din_i;
            assign pre_o   = din_i;
        end else begin : g_multi
            assign stage_d = {stage_q[DEPTH-2:0], din_i};
            assign pre_o   = stage_q[DEPTH-2];
        end
    endgenerate

    assign dout_o = stage_q[DEPTH-1];

    // Stage registers: clear on reset, shift on tick, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= stage_d;
        end else begin
            stage_q <= stage_q;
        end
    end

endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: composites N_LAYERS graphic layers by fixed priority
// (lowest index wins) over a background colour, then delays colour and
// sync together by PIPE_DEPTH pixel ticks. Also counts frames.
// Optional feature macro: VGA_MIXER_TEST_PATTERN_EN adds test_en and a
// colour-bar generator driven by pix_x[9:7].
// Ports:
//   clk, reset (sync, active-high), p_tick (pixel enable)
//   video_on, hsync_in, vsync_in : raw timing from vga_sync
//   pix_x                        : column, used only by the test pattern
//   layer_on, layer_mask         : per-layer hit flags and runtime enables
//   layer_rgb, bg_rgb            : layer i colour at [i*RGB_W +: RGB_W], background
//   test_en                      : bar enable (macro builds only)
//   hsync, vsync, video_on_out, rgb : delayed, registered outputs
//   frame_cnt, frame_start       : frame counter and registered rise pulse
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int unsigned RGB_W      = RGB_W_DEFAULT,
    parameter int unsigned N_LAYERS   = 32'd4,
    parameter int unsigned PIPE_DEPTH = 32'd2,
    parameter int unsigned FRAME_W    = 32'd8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p_tick,
    input  logic                      video_on,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic [COORD_W-1:0]        pix_x,
    input  logic [N_LAYERS-1:0]       layer_on,
    input  logic [N_LAYERS-1:0]       layer_mask,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]          bg_rgb,
`ifdef VGA_MIXER_TEST_PATTERN_EN
    input  logic                      test_en,
`endif
    output logic                      hsync,
    output logic                      vsync,
    output logic                      video_on_out,
    output logic [RGB_W-1:0]          rgb,
    output logic [FRAME_W-1:0]        frame_cnt,
    output logic                      frame_start
);

    localparam int unsigned BUNDLE_W = RGB_W + 32'd3;

    logic [RGB_W-1:0]    mix_s;
    logic [RGB_W-1:0]    stage0_rgb_s;
    logic [BUNDLE_W-1:0] stage0_s;
    logic [BUNDLE_W-1:0] last_s;
    logic [BUNDLE_W-1:0] pre_last_s;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                frame_start_q, frame_start_d;

    // Priority mux: scan from the highest index down so the lowest eligible index wins.
    always_comb begin
        mix_s = bg_rgb;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (layer_on[i] & layer_mask[i]) begin
                mix_s = layer_rgb[i*RGB_W +: RGB_W];
            end else begin
                mix_s = mix_s;
            end
        end
    end

`ifdef VGA_MIXER_TEST_PATTERN_EN
    logic [RGB_MAX_W-1:0] bar_full_s;
    logic                 unused_pix_s;
    assign bar_full_s   = color_bar(pix_x[9:7], RGB_W / 32'd3);
    assign unused_pix_s = ^{bar_full_s[RGB_MAX_W-1:RGB_W], pix_x[6:0]};

    // Stage 0: blanking forces black, then test bars, then the layer mix.
    always_comb begin
        if (!video_on) begin
            stage0_rgb_s = '0;
        end else if (test_en) begin
            stage0_rgb_s = bar_full_s[RGB_W-1:0];
        end else begin
            stage0_rgb_s = mix_s;
        end
    end
`else
    logic unused_pix_s;
    assign unused_pix_s = ^pix_x;

    // Stage 0: blanking forces black, otherwise the layer mix.
    always_comb begin
        if (!video_on) begin
            stage0_rgb_s = '0;
        end else begin
            stage0_rgb_s = mix_s;
        end
    end
`endif

    assign stage0_s = {stage0_rgb_s, hsync_in, vsync_in, video_on};

    vga_delay_line #(
        .WIDTH (BUNDLE_W),
        .DEPTH (PIPE_DEPTH)
    ) u_delay (
        .clk_i  (clk),
        .srst_i (reset),
        .en_i   (p_tick),
        .din_i  (stage0_s),
        .dout_o (last_s),
        .pre_o  (pre_last_s)
    );

    assign rgb          = last_s[BUNDLE_W-1 -: RGB_W];
    assign hsync        = last_s[2];
    assign vsync        = last_s[1];
    assign video_on_out = last_s[0];

    logic unused_pre_s;
    assign unused_pre_s = ^{pre_last_s[BUNDLE_W-1:2], pre_last_s[0]};

    // Output vsync rises on this edge when it is low now and a 1 is about to shift in.
    always_comb begin
        if (p_tick && pre_last_s[1] && !vsync) begin
            frame_cnt_d   = frame_cnt_q + FRAME_W'(1);
            frame_start_d = 1'b1;
        end else begin
            frame_cnt_d   = frame_cnt_q;
            frame_start_d = 1'b0;
        end
    end

    // Frame counter and start pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
module tb_vga_layer_mixer;

    localparam int RGB_W = 3;
    localparam int NL    = 4;
    localparam int D     = 2;
    localparam int FW    = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            p_tick;
    logic            video_on;
    logic            hsync_in;
    logic            vsync_in;
    logic [9:0]      pix_x;
    logic [NL-1:0]   layer_on;
    logic [NL-1:0]   layer_mask;
    logic [NL*3-1:0] layer_rgb;
    logic [2:0]      bg_rgb;
    logic            test_en;
    logic            hsync, vsync, video_on_out, frame_start;
    logic [2:0]      rgb;
    logic [FW-1:0]   frame_cnt;

    always #5 clk = ~clk;

    vga_layer_mixer #(
        .RGB_W(RGB_W), .N_LAYERS(NL), .PIPE_DEPTH(D), .FRAME_W(FW)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pix_x(pix_x),
        .layer_on(layer_on), .layer_mask(layer_mask), .layer_rgb(layer_rgb),
        .bg_rgb(bg_rgb),
`ifdef VGA_MIXER_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .hsync(hsync), .vsync(vsync), .video_on_out(video_on_out), .rgb(rgb),
        .frame_cnt(frame_cnt), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       vo;
    } pix_t;

    typedef struct packed {
        logic [2:0]    rgb;
        logic          hs;
        logic          vs;
        logic          vo;
        logic [FW-1:0] cnt;
        logic          start;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    pix_t samples[$];   // every stage-0 value captured since the last reset
    exp_t cur = '0;
    int   starts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Stage-0 value straight from the rules: blank, bars, first eligible layer, background.
    function automatic pix_t ref_stage0();
        pix_t p;
        int   b;
        p.hs = hsync_in;
        p.vs = vsync_in;
        p.vo = video_on;
        p.rgb = bg_rgb;
        if (!video_on) begin
            p.rgb = 3'd0;
            return p;
        end
`ifdef VGA_MIXER_TEST_PATTERN_EN
        if (test_en) begin
            b = int'(pix_x) / 128;
            p.rgb = {1'((b / 4) % 2), 1'((b / 2) % 2), 1'(b % 2)};
            return p;
        end
`endif
        for (int i = 0; i < NL; i++) begin
            if (layer_on[i] && layer_mask[i]) begin
                p.rgb = layer_rgb[i*3 +: 3];
                return p;
            end
        end
        return p;
    endfunction

    // Model of one clk edge: outputs show the sample taken D ticks ago.
    task automatic model_edge();
        pix_t nxt;
        if (reset) begin
            samples.delete();
            cur = '0;
        end else if (p_tick) begin
            samples.push_back(ref_stage0());
            if (samples.size() >= D) nxt = samples[samples.size() - D];
            else nxt = '0;
            cur.start = (!cur.vs && nxt.vs);
            if (cur.start) cur.cnt = cur.cnt + 1'b1;
            cur.rgb = nxt.rgb;
            cur.hs  = nxt.hs;
            cur.vs  = nxt.vs;
            cur.vo  = nxt.vo;
        end else begin
            cur.start = 1'b0;
        end
        exp_q.push_back(cur);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        video_on   = 1'($urandom_range(0, 3) != 0);
        hsync_in   = 1'($urandom);
        vsync_in   = 1'($urandom);
        pix_x      = 10'($urandom);
        layer_on   = NL'($urandom);
        layer_mask = NL'($urandom);
        layer_rgb  = (NL*3)'($urandom);
        bg_rgb     = 3'($urandom);
`ifdef VGA_MIXER_TEST_PATTERN_EN
        test_en    = 1'($urandom_range(0, 3) == 0);
`endif
    endtask

    // Monitor: one DUT observation per clk, compared against the scoreboard head.
    initial begin
        exp_t        e;
        logic [14:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {rgb, hsync, vsync, video_on_out, frame_cnt, frame_start};
                check("scoreboard", {17'd0, got}, {17'd0, 15'(e)});
            end
        end
    end

    initial begin
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        pix_x = '0; layer_on = '0; layer_mask = '0; layer_rgb = '0; bg_rgb = '0; test_en = 1'b0;

        // reset held with p_tick toggling and syncs high
        for (int i = 0; i < 4; i++) begin
            p_tick = ~p_tick;
            cyc();
            check("reset_outputs", {17'd0, rgb, hsync, vsync, video_on_out, frame_cnt, frame_start}, 32'd0);
        end
        reset = 1'b0;

        // priority
        p_tick = 1'b1; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        layer_on = 4'b0110; layer_mask = 4'b1111;
        layer_rgb = {3'b111, 3'b100, 3'b010, 3'b001}; bg_rgb = 3'b101;
        cyc(); cyc();
        check("prio_layer1", {29'd0, rgb}, {29'd0, 3'b010});
        layer_mask = 4'b1101;
        cyc(); cyc();
        check("prio_layer2", {29'd0, rgb}, {29'd0, 3'b100});

        // blanking and background
        video_on = 1'b0;
        cyc(); cyc();
        check("blank", {29'd0, rgb}, 32'd0);
        video_on = 1'b1; layer_on = 4'b0000; bg_rgb = 3'b001;
        cyc(); cyc();
        check("background", {29'd0, rgb}, {29'd0, 3'b001});

        // hsync alignment
        hsync_in = 1'b1;
        cyc();
        hsync_in = 1'b0;
        check("hsync_tick1", {31'd0, hsync}, 32'd0);
        cyc();
        check("hsync_tick2", {28'd0, hsync, rgb}, {28'd0, 1'b1, 3'b001});
        cyc();
        check("hsync_tick3", {31'd0, hsync}, 32'd0);

        // stall: inputs change, nothing moves
        p_tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            cyc();
        end
        p_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            cyc();
        end

`ifdef VGA_MIXER_TEST_PATTERN_EN
        test_en = 1'b1; video_on = 1'b1; pix_x = 10'd384;
        cyc(); cyc();
        check("bars_384", {29'd0, rgb}, {29'd0, 3'b011});
        video_on = 1'b0;
        cyc(); cyc();
        check("bars_blank", {29'd0, rgb}, 32'd0);
        test_en = 1'b0;
`endif

        // frame counter: 257 vsync pulses after a fresh reset
        reset = 1'b1; vsync_in = 1'b0; p_tick = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        starts = 0;
        for (int k = 0; k < 257; k++) begin
            for (int j = 0; j < 4; j++) begin
                vsync_in = (j < 2);
                cyc();
                if (frame_start) starts++;
                if (k == 255 && j == 3) check("frame_wrap", {24'd0, frame_cnt}, 32'd0);
            end
        end
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (frame_start) starts++;
        end
        check("frame_final", {24'd0, frame_cnt}, 32'd1);
        check("frame_pulses", starts, 32'd257);

        // random traffic with occasional stalls and resets
        for (int i = 0; i < 800; i++) begin
            randomize_inputs();
            p_tick = 1'($urandom_range(0, 3) != 0);
            reset  = 1'($urandom_range(0, 60) == 0);
            cyc();
        end

        reset = 1'b0; p_tick = 1'b0;
        cyc(); cyc(); cyc();
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised pixel output stage for the VGA display path. It sits between the `vga_sync` timing generator and the board pins. It composites N graphic layers by fixed priority over a background colour and registers the result on the pixel tick. It also delays `hsync`, `vsync` and `video_on` by the same pipeline depth so colour and sync stay aligned. A frame counter and a start-of-frame pulse are provided for animation logic.

## Interface
Parameters:
- `RGB_W`, default 3: pixel colour width; must be a multiple of 3 (R, G, B fields of `RGB_W/3` bits, R in the MSBs).
- `N_LAYERS`, default 4: number of graphic layers; minimum 1.
- `PIPE_DEPTH`, default 2: pixel-tick pipeline stages; minimum 1.
- `FRAME_W`, default 8: frame counter width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `p_tick` in 1: pixel-rate enable from `vga_sync`.
- `video_on` in 1: visible-area flag from `vga_sync`.
- `hsync_in` in 1: horizontal sync from `vga_sync`, active-high during retrace.
- `vsync_in` in 1: vertical sync from `vga_sync`, active-high during retrace.
- `pix_x` in 10: current pixel column; used only by the test pattern.
- `layer_on` in N_LAYERS: per-layer "pixel inside object" flags.
- `layer_mask` in N_LAYERS: runtime layer enables.
- `layer_rgb` in N_LAYERS*RGB_W: layer i colour at `[i*RGB_W +: RGB_W]`.
- `bg_rgb` in RGB_W: background colour.
- `test_en` in 1: present only with `VGA_MIXER_TEST_PATTERN_EN`.
- `hsync` out 1: delayed horizontal sync.
- `vsync` out 1: delayed vertical sync.
- `video_on_out` out 1: delayed visible-area flag.
- `rgb` out RGB_W: composited colour.
- `frame_cnt` out FRAME_W: completed-frame counter.
- `frame_start` out 1: one-clk pulse when output `vsync` rises.

## Operation
- Stage 0 is combinational; the selection is evaluated in this order:
  1. If `!video_on`, the value is 0.
  2. Otherwise, layer i is eligible when `layer_on[i] & layer_mask[i]`; the eligible layer with the lowest index wins and its `layer_rgb` is selected.
  3. If no layer is eligible, `bg_rgb` is selected.
- Stage 0 and the raw `hsync_in`, `vsync_in` and `video_on` form one bundle, captured into stage 1 on `clk` when `p_tick=1`. Stages k>1 shift from k-1 on the same ticks.
- Outputs come directly from stage PIPE_DEPTH registers. There is no combinational path from inputs to outputs.
- When `p_tick=0`, all stages and outputs hold.
- Frame counter: on a clk with `p_tick=1` where the last-stage `vsync` goes 0→1:
  - `frame_cnt` increments, wrapping from 2^FRAME_W−1 to 0;
  - `frame_start` is 1 for exactly that clk cycle.
  - `frame_start` is 0 on every other cycle.
- Reset has priority over `p_tick`. It clears all stages, `rgb`, `hsync`, `vsync`, `video_on_out`, `frame_cnt` and `frame_start` to 0 on that edge, including mid-frame. The first rising edge of output `vsync` after reset counts as a frame.
- `layer_mask` and `bg_rgb` changes take effect on the next capturing tick. There are no glitches between ticks.

## Timing
- Latency: the output reflects stage 0 as sampled PIPE_DEPTH `p_tick` pulses earlier. Sync and colour latency are identical.
- Output update happens on the clk edge where `p_tick=1`. All outputs are stable for the whole pixel period.
- `frame_start` is registered and coincides with the cycle in which output `vsync` first reads 1.
- Back-to-back `p_tick` every clk is legal; the pipeline then runs at clk rate.

## Configuration
- `VGA_MIXER_TEST_PATTERN_EN` defined:
  - Adds the `test_en` port.
  - When `test_en=1` and `video_on=1`, stage 0 is replaced by colour bars: with b = `pix_x[9:7]`, the R, G and B fields are all-ones if b[2], b[1] and b[0] respectively are set, else 0.
  - Blanking still forces 0.
- Macro undefined: no `test_en` port, `pix_x` is unused, and the layer mixer is always active.

## Structure
- Shared package `vga_pkg`:
  - screen constants (640×480, 10-bit coordinate width);
  - default `RGB_W`;
  - the colour-bar field expansion function.
- One sub-module, `vga_delay_line`: a parametrised width×depth shift register enabled by `p_tick` with synchronous reset. It is instantiated once for the {rgb, hsync, vsync, video_on} bundle.

## Test plan
- Reset: assert `reset` with `p_tick` toggling and sync inputs high → all outputs 0 and `frame_cnt`=0 on the next edge and while `reset` is held.
- Priority: RGB_W=3, PIPE_DEPTH=2, `layer_on`=0110, `layer_mask`=1111, layer1=010, layer2=100 → `rgb`=010 after 2 ticks; then `layer_mask`=1101 → `rgb`=100 two ticks later.
- Blanking/background:
  - `video_on`=0 with layers on → `rgb`=000;
  - `video_on`=1, `layer_on`=0000, `bg_rgb`=001 → `rgb`=001;
  - `hsync` pulse emerges exactly 2 ticks after `hsync_in`, aligned with the colour.
- Stall: hold `p_tick`=0 for 5 clks while changing all inputs → outputs unchanged; resume → the pipeline resumes from the held contents.
- Frame counter: 257 `vsync_in` pulses → `frame_cnt` goes 255→0→1. Each `frame_start` is 1 clk wide, in the same cycle that `vsync` rises.
- Test pattern (macro on): `test_en`=1, `video_on`=1, `pix_x`=384 → `rgb`=011 after 2 ticks; `video_on`=0 → 000.
